// File: rtl/wb_stage_pkg.sv
// Shared definitions for the MIPS writeback stage: load-type encodings,
// the link-address offset and the MEM/WB stage-register payload.
package wb_stage_pkg;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    localparam logic [31:0] WB_LINK_OFS = 32'd8;

    // Everything latched from MEM except valid and the destination address,
    // which are kept beside it because valid is handled separately on a flush.
    typedef struct packed {
        logic        we;
        logic [31:0] alu_result;
        logic        is_load;
        logic [2:0]  load_type;
        logic [31:0] rdata;
        logic        link;
        logic [31:0] pc;
    } wb_fields_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Big-endian load extraction: selects the byte or halfword from a memory word,
// sign- or zero-extends it, and flags misaligned word/halfword accesses.
module wb_stage_load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  type_i,
    output logic [31:0] data_o,
    output logic        err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Offset 0 is the most significant byte in big-endian order.
    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = rdata_i[31:24];
            2'd1:    byte_sel = rdata_i[23:16];
            2'd2:    byte_sel = rdata_i[15:8];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    end

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        data_o = rdata_i;
        err_o  = |offset_i;
        case (type_i)
            LD_LH: begin
                data_o = {{16{half_sel[15]}}, half_sel};
                err_o  = offset_i[0];
            end
            LD_LHU: begin
                data_o = {16'h0000, half_sel};
                err_o  = offset_i[0];
            end
            LD_LB: begin
                data_o = {{24{byte_sel[7]}}, byte_sel};
                err_o  = 1'b0;
            end
            LD_LBU: begin
                data_o = {24'h000000, byte_sel};
                err_o  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: MEM/WB register, writeback data selection, register-file
// write port, forwarding tap and retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_wt_addr,
    input  logic [31:0]       mem_alu_result,
    input  logic              mem_is_load,
    input  logic [2:0]        mem_load_type,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_link,
    input  logic [31:0]       mem_pc,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_Wt_addr,
    output logic [31:0]       reg_wdata,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [31:0]       fwd_data,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  instret
);

    wb_fields_t        fields_q, fields_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic [31:0] load_data;
    logic        align_err;
    logic        err;
    logic        retire;
    logic        wr_ok;

    // Flush beats stall: the slot is squashed even while the pipeline is frozen.
    always_comb begin
        fields_d = fields_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            fields_d.we         = mem_we;
            fields_d.alu_result = mem_alu_result;
            fields_d.is_load    = mem_is_load;
            fields_d.load_type  = mem_load_type;
            fields_d.rdata      = mem_rdata;
            fields_d.link       = mem_link;
            fields_d.pc         = mem_pc;
            addr_d              = mem_wt_addr;
            valid_d             = mem_valid;
        end
    end

    assign retire    = valid_q & ~stall;
    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    // NOTE: clocked state uses non-blocking assignments only; reset is synchronous,
    // so it is just the highest-priority branch evaluated on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fields_q  <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            fields_q  <= fields_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            instret_q <= instret_d;
        end
    end

    wb_stage_load_align u_load_align (
        .rdata_i  (fields_q.rdata),
        .offset_i (fields_q.alu_result[1:0]),
        .type_i   (fields_q.load_type),
        .data_o   (load_data),
        .err_o    (align_err)
    );

    // A link instruction never faults, even if its is_load bit is set.
    assign err   = fields_q.is_load & ~fields_q.link & align_err;
    assign wr_ok = fields_q.we & (addr_q != '0) & ~err;

    always_comb begin
        if (fields_q.link) begin
            reg_wdata = fields_q.pc + WB_LINK_OFS;
        end else if (fields_q.is_load) begin
            reg_wdata = load_data;
        end else begin
            reg_wdata = fields_q.alu_result;
        end
    end

    assign reg_we       = retire & wr_ok;
    assign reg_Wt_addr  = addr_q;
    assign misalign_err = retire & err;
    assign instret      = instret_q;

    // The tap stays valid through a stall so ID can keep bypassing a held result.
    assign fwd_valid = valid_q & wr_ok;
    assign fwd_addr  = addr_q;
    assign fwd_data  = reg_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes the expected retire record,
// a negedge monitor pops it whenever the retired-instruction counter advances.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        mem_valid, mem_we, mem_is_load, mem_link;
    logic [4:0]  mem_wt_addr;
    logic [31:0] mem_alu_result, mem_rdata, mem_pc;
    logic [2:0]  mem_load_type;

    logic        reg_we, fwd_valid, misalign_err;
    logic [4:0]  reg_Wt_addr, fwd_addr;
    logic [31:0] reg_wdata, fwd_data, instret;

    logic        w_reg_we, w_fwd_valid, w_misalign_err;
    logic [4:0]  w_reg_Wt_addr, w_fwd_addr;
    logic [31:0] w_reg_wdata, w_fwd_data;
    logic [3:0]  instret_w;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_wt_addr(mem_wt_addr),
        .mem_alu_result(mem_alu_result), .mem_is_load(mem_is_load),
        .mem_load_type(mem_load_type), .mem_rdata(mem_rdata), .mem_link(mem_link),
        .mem_pc(mem_pc), .reg_we(reg_we), .reg_Wt_addr(reg_Wt_addr),
        .reg_wdata(reg_wdata), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .misalign_err(misalign_err), .instret(instret)
    );

    // Narrow counter copy: lets the wrap from all-ones to zero be reached quickly.
    wb_stage #(.ADDR_W(5), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_wt_addr(mem_wt_addr),
        .mem_alu_result(mem_alu_result), .mem_is_load(mem_is_load),
        .mem_load_type(mem_load_type), .mem_rdata(mem_rdata), .mem_link(mem_link),
        .mem_pc(mem_pc), .reg_we(w_reg_we), .reg_Wt_addr(w_reg_Wt_addr),
        .reg_wdata(w_reg_wdata), .fwd_valid(w_fwd_valid), .fwd_addr(w_fwd_addr),
        .fwd_data(w_fwd_data), .misalign_err(w_misalign_err), .instret(instret_w)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_issued = 0;

    localparam logic [31:0] RD = 32'h80FF_7F01;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [4:0] addr, input logic [31:0] alu,
                         input logic ld, input logic [2:0] lt, input logic [31:0] rd,
                         input logic lk, input logic [31:0] pc, input logic retires,
                         input logic e_we, input logic [31:0] e_wdata, input logic e_err);
        mem_we         = we;
        mem_wt_addr    = addr;
        mem_alu_result = alu;
        mem_is_load    = ld;
        mem_load_type  = lt;
        mem_rdata      = rd;
        mem_link       = lk;
        mem_pc         = pc;
        mem_valid      = 1'b1;
        if (retires) begin
            exp_q.push_back('{e_we, addr, e_wdata, e_err});
            n_issued++;
        end
        step();
        mem_valid = 1'b0;
    endtask

    task automatic alu_op(input logic [4:0] addr, input logic [31:0] val);
        issue(1'b1, addr, val, 1'b0, LD_LW, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, val, 1'b0);
    endtask

    task automatic load_op(input logic [2:0] lt, input logic [31:0] alu, input logic [4:0] addr,
                           input logic [31:0] e_data, input logic e_err);
        issue(1'b1, addr, alu, 1'b1, lt, RD, 1'b0, 32'h0, 1'b1, ~e_err, e_data, e_err);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: an instret change at this negedge means the previous cycle retired.
    logic        prev_we, prev_err, prev_fwd;
    logic [4:0]  prev_addr, prev_faddr;
    logic [31:0] prev_wdata, prev_fdata, last_cnt, model_cnt;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            model_cnt = 32'd0;
            last_cnt  = 32'd0;
            prev_we   = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (instret != last_cnt) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", instret, last_cnt);
                end else begin
                    mon_e = exp_q.pop_front();
                    model_cnt = model_cnt + 32'd1;
                    check("retire_reg_we", 32'(prev_we), 32'(mon_e.we));
                    check("retire_fwd_valid", 32'(prev_fwd), 32'(mon_e.we));
                    check("retire_misalign", 32'(prev_err), 32'(mon_e.err));
                    if (mon_e.we) begin
                        check("retire_addr", 32'(prev_addr), 32'(mon_e.addr));
                        check("retire_wdata", prev_wdata, mon_e.wdata);
                        check("retire_fwd_addr", 32'(prev_faddr), 32'(mon_e.addr));
                        check("retire_fwd_data", prev_fdata, mon_e.wdata);
                    end
                    check("instret", instret, model_cnt);
                end
            end else begin
                check("idle_reg_we", 32'(prev_we), 32'd0);
                check("idle_misalign", 32'(prev_err), 32'd0);
            end
            last_cnt = instret;
        end
        prev_we    = reg_we;
        prev_err   = misalign_err;
        prev_fwd   = fwd_valid;
        prev_addr  = reg_Wt_addr;
        prev_wdata = reg_wdata;
        prev_faddr = fwd_addr;
        prev_fdata = fwd_data;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_valid = 1'b1; mem_we = 1'b1; mem_wt_addr = 5'd9; mem_alu_result = 32'hDEAD_BEEF;
        mem_is_load = 1'b0; mem_load_type = LD_LW; mem_rdata = 32'h0; mem_link = 1'b0;
        mem_pc = 32'h0;

        // Two reset cycles with a live instruction at the input.
        step(); step();
        @(negedge clk);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_wdata", reg_wdata, 32'd0);
        check("rst_addr", 32'(reg_Wt_addr), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        step();

        rst_n = 1'b1;
        alu_op(5'd5, 32'h1234_5678);
        @(negedge clk);
        check("first_retire_we", 32'(reg_we), 32'd1);
        check("first_retire_wdata", reg_wdata, 32'h1234_5678);
        step();

        // Big-endian load alignment, back to back, rdata = 0x80FF7F01.
        load_op(LD_LB,  32'h0000_0103, 5'd6,  32'h0000_0001, 1'b0);
        load_op(LD_LB,  32'h0000_0100, 5'd7,  32'hFFFF_FF80, 1'b0);
        load_op(LD_LBU, 32'h0000_0101, 5'd8,  32'h0000_00FF, 1'b0);
        load_op(LD_LH,  32'h0000_0102, 5'd9,  32'h0000_7F01, 1'b0);
        load_op(LD_LHU, 32'h0000_0100, 5'd10, 32'h0000_80FF, 1'b0);
        load_op(LD_LH,  32'h0000_0100, 5'd11, 32'hFFFF_80FF, 1'b0);
        load_op(LD_LBU, 32'h0000_0102, 5'd12, 32'h0000_007F, 1'b0);
        load_op(LD_LW,  32'h0000_0104, 5'd13, 32'h80FF_7F01, 1'b0);
        load_op(3'd6,   32'h0000_0200, 5'd14, 32'h80FF_7F01, 1'b0);

        // Misaligned accesses: no write, one-cycle error pulse, still counted.
        load_op(LD_LW,  32'h0000_1002, 5'd15, 32'h0, 1'b1);
        step();
        load_op(LD_LH,  32'h0000_0101, 5'd16, 32'h0, 1'b1);
        load_op(LD_LHU, 32'h0000_0103, 5'd17, 32'h0, 1'b1);
        load_op(3'd7,   32'h0000_0201, 5'd18, 32'h0, 1'b1);
        step();

        // Link wins over a misaligned load, and pc+8 wraps modulo 2^32.
        issue(1'b1, 5'd31, 32'h0000_1003, 1'b1, LD_LW, RD, 1'b1, 32'h0040_0010,
              1'b1, 1'b1, 32'h0040_0018, 1'b0);
        issue(1'b1, 5'd4, 32'h0, 1'b0, LD_LW, 32'h0, 1'b1, 32'hFFFF_FFFC,
              1'b1, 1'b1, 32'h0000_0004, 1'b0);
        // $0 and we=0: no write, still retire.
        issue(1'b1, 5'd0, 32'hAAAA_5555, 1'b0, LD_LW, 32'h0, 1'b0, 32'h0,
              1'b1, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 5'd7, 32'h5555_AAAA, 1'b0, LD_LW, 32'h0, 1'b0, 32'h0,
              1'b1, 1'b0, 32'h0, 1'b0);
        drain();

        // Three-cycle stall: held, forwarded, then exactly one retire.
        alu_op(5'd20, 32'hCAFE_0001);
        stall = 1'b1;
        @(negedge clk);
        check("stall_reg_we", 32'(reg_we), 32'd0);
        check("stall_fwd_valid", 32'(fwd_valid), 32'd1);
        check("stall_fwd_data", fwd_data, 32'hCAFE_0001);
        step(); step(); step();
        stall = 1'b0;
        drain();

        // Stall and flush together: squashed, never retires.
        issue(1'b1, 5'd21, 32'hBAD0_0001, 1'b0, LD_LW, 32'h0, 1'b0, 32'h0,
              1'b0, 1'b0, 32'h0, 1'b0);
        stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_fwd_valid", 32'(fwd_valid), 32'd0);
        drain();

        // Reset while a stalled instruction sits in WB: reset wins.
        issue(1'b1, 5'd3, 32'hBAD0_0002, 1'b0, LD_LW, 32'h0, 1'b0, 32'h0,
              1'b0, 1'b0, 32'h0, 1'b0);
        stall = 1'b1;
        step();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1; stall = 1'b0;
        n_issued = 0;
        @(negedge clk);
        check("rst_stall_reg_we", 32'(reg_we), 32'd0);
        check("rst_stall_instret", instret, 32'd0);
        check("rst_stall_wdata", reg_wdata, 32'd0);
        check("rst_stall_addr", 32'(reg_Wt_addr), 32'd0);
        step();

        // Counter wrap on the 4-bit copy: all-ones then zero.
        while (n_issued % 16 != 15) alu_op(5'(1 + n_issued % 30), 32'(n_issued));
        drain();
        check("wrap_pre_w", 32'(instret_w), 32'h0000_000F);
        check("wrap_pre_main", instret, 32'd15);
        alu_op(5'd2, 32'h0000_0F0F);
        drain();
        check("wrap_post_w", 32'(instret_w), 32'd0);
        check("wrap_post_main", instret, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
